mmio_responder_v: RTL

MMIO_RESPONDER_V -- requirements
Module: mmio_responder_v

---
 rtl/mmio_responder_v.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mmio_responder_v.sv
// mmio_responder_v: memory-mapped peripheral block occupying a 256-byte window.
// It provides a control register, sticky status flags, a free-running timer
// with a compare/wrap, a byte TX FIFO and a 16-bit GPIO output register.
//
// Ports
//   CLK        single clock, rising edge
//   RESET      asynchronous reset, active low
//   DataAdr    processor byte address
//   WriteData  processor store data
//   MemWrite   store strobe (one cycle)
//   ReadData   load data, combinational from DataAdr and current state
//   Sel        DataAdr falls inside the window
//   tx_data    FIFO head byte (0 when empty)
//   tx_valid   FIFO not empty
//   tx_ready   consumer takes the head byte this cycle
//   gpio_out   GPIO output register
//   irq        registered interrupt request
//
// Register map (offset = DataAdr[7:2])
//   0x00 CTRL    [0] timer_en, [1] irq_en
//   0x04 STATUS  [0] empty, [1] full, [2] match (W1C), [3] overflow (W1C)
//   0x08 TIMER   32-bit
//   0x0C COMPARE 32-bit
//   0x10 TXDATA  write pushes WriteData[7:0], read returns the FIFO count
//   0x14 GPIO    [15:0]
module mmio_responder_v #(
    parameter logic [31:0] BASE_ADDR  = 32'hFFFF_FF00,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    input  logic        MemWrite,
    output logic [31:0] ReadData,
    output logic        Sel,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [15:0] gpio_out,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    localparam logic [5:0] OFF_CTRL   = 6'h00;
    localparam logic [5:0] OFF_STATUS = 6'h01;
    localparam logic [5:0] OFF_TIMER  = 6'h02;
    localparam logic [5:0] OFF_CMP    = 6'h03;
    localparam logic [5:0] OFF_TX     = 6'h04;
    localparam logic [5:0] OFF_GPIO   = 6'h05;

    logic [1:0]                  ctrl;
    logic [31:0]                 timer;
    logic [31:0]                 compare;
    logic [15:0]                 gpio;
    logic                        match;
    logic                        overflow;
    logic [FIFO_DEPTH-1:0][7:0]  mem;
    logic [AW-1:0]               wptr;
    logic [AW-1:0]               rptr;
    logic [CW-1:0]               count;

    logic [5:0] off;
    logic       wr;
    logic       empty;
    logic       full;
    logic       push;
    logic       pop;
    logic       accept;
    logic       hit;
    logic       ovf_set;
    logic       clr_match;
    logic       clr_ovf;

    // Byte-lane bits of the address are don't-care for word registers.
    logic unused_adr;
    assign unused_adr = ^DataAdr[1:0];

    assign Sel   = (DataAdr[31:8] == BASE_ADDR[31:8]);
    assign off   = DataAdr[7:2];
    assign wr    = MemWrite && Sel;

    assign empty = (count == '0);
    assign full  = (count == CW'(FIFO_DEPTH));

    assign tx_valid = !empty;
    // Gate on valid so the byte reads 0 in reset/empty rather than a stale slot.
    assign tx_data  = tx_valid ? mem[rptr] : 8'h00;

    assign pop     = tx_valid && tx_ready;
    assign push    = wr && (off == OFF_TX);
    // When full, a concurrent pop frees the head slot, which is exactly wptr.
    assign accept  = push && (!full || pop);
    assign ovf_set = push && full && !pop;

    assign hit       = ctrl[0] && (timer == compare);
    assign clr_match = wr && (off == OFF_STATUS) && WriteData[2];
    assign clr_ovf   = wr && (off == OFF_STATUS) && WriteData[3];

    assign gpio_out = gpio;

    always_comb begin
        ReadData = '0;
        if (Sel) begin
            case (off)
                OFF_CTRL:   ReadData = {30'b0, ctrl};
                OFF_STATUS: ReadData = {28'b0, overflow, match, full, empty};
                OFF_TIMER:  ReadData = timer;
                OFF_CMP:    ReadData = compare;
                OFF_TX:     ReadData = 32'(count);
                OFF_GPIO:   ReadData = {16'b0, gpio};
                default:    ReadData = '0;
            endcase
        end
    end

    // Control, timer and flags.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            ctrl     <= '0;
            timer    <= '0;
            compare  <= '0;
            gpio     <= '0;
            match    <= 1'b0;
            overflow <= 1'b0;
            irq      <= 1'b0;
        end else begin
            if (wr && off == OFF_CTRL) ctrl    <= WriteData[1:0];
            if (wr && off == OFF_CMP)  compare <= WriteData;
            if (wr && off == OFF_GPIO) gpio    <= WriteData[15:0];

            // A software write to TIMER takes priority over count/wrap.
            if (wr && off == OFF_TIMER) timer <= WriteData;
            else if (ctrl[0])           timer <= hit ? 32'd0 : timer + 32'd1;

            // Set beats W1C so a coincident event is never lost.
            match    <= hit     | (match    & ~clr_match);
            overflow <= ovf_set | (overflow & ~clr_ovf);

            irq <= ctrl[1] && (match || overflow);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: empty pointers make old contents unreachable.
    always_ff @(posedge CLK) begin
        if (accept) mem[wptr] <= WriteData[7:0];
    end
endmodule
